// File: rtl/merge_arb_pkg.sv
// Purpose: shared constants and helpers for the merge arbiter and its round-robin grant logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: idx_width() gives the winner-index width (clog2, at least 1 bit);
//           last_rst() gives the pointer reset value so that input 0 has first priority.
package merge_arb_pkg;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointer holds the most recent winner; resetting it to n-1 makes the
    // first search start at input 0.
    function automatic int last_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/merge_arbiter_break_dvr_rr_arbiter.sv
// Purpose: combinational round-robin grant; search starts one past ptr and wraps modulo N.
// Latency: zero cycles (pure combinational).
// Backpressure: none; grant simply follows req, no state kept here.
// Ports: req (N request bits), ptr (last winner), grant (one-hot or zero),
//        winner (binary index of granted bit), any (a grant exists).
module rr_arbiter
    import merge_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner,
    output logic          any
);

    always_comb begin
        int          start;
        logic [IW-1:0] sel;
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        sel    = '0;
        // Modulo keeps the wrap correct for non-power-of-two N.
        start  = (int'(ptr) + 1) % N;
        for (int k = 0; k < N; k++) begin
            sel = IW'((start + k) % N);
            if (!any && req[sel]) begin
                grant[sel] = 1'b1;
                winner     = sel;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/merge_arbiter_break_dvr.sv
// Purpose: N-input merge into a single one-slot break-DVR register (data, valid and ready all cut).
// Latency: accept in cycle t -> outs_valid in t+1; max one token every 2 cycles.
// Backpressure: ins_ready is zero while the slot is full; it never looks at outs_ready.
// Ports: ins/ins_valid/ins_ready (packed producers, input i at [i*DATA_TYPE +: DATA_TYPE]),
//        outs/outs_valid/outs_ready (registered consumer side), index (source of current payload).
// Config: define MERGE_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority (no pointer).
module merge_arbiter_break_dvr
    import merge_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_TYPE  = 32,
    parameter int INDEX_TYPE = idx_width(NUM_INPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_INPUTS*DATA_TYPE-1:0] ins,
    input  logic [NUM_INPUTS-1:0]           ins_valid,
    output logic [NUM_INPUTS-1:0]           ins_ready,
    output logic [DATA_TYPE-1:0]            outs,
    output logic                            outs_valid,
    input  logic                            outs_ready,
    output logic [INDEX_TYPE-1:0]           index
);

    logic                  full;
    logic [DATA_TYPE-1:0]  data_reg;
    logic [INDEX_TYPE-1:0] idx_reg;
    logic [NUM_INPUTS-1:0] grant;
    logic [INDEX_TYPE-1:0] winner;
    logic                  any_grant;
    logic [INDEX_TYPE-1:0] ptr;
    logic                  accept;
    logic [DATA_TYPE-1:0]  ins_arr [NUM_INPUTS];

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
        assign ins_arr[i] = ins[i*DATA_TYPE +: DATA_TYPE];
    end

`ifdef MERGE_ARB_FIXED_PRIORITY_EN
    // A constant pointer of N-1 makes every search start at input 0.
    assign ptr = INDEX_TYPE'(last_rst(NUM_INPUTS));
`else
    logic [INDEX_TYPE-1:0] last;

    // Pointer moves only on an actual accept, so a withdrawn grant
    // re-arbitrates from the same place next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= INDEX_TYPE'(last_rst(NUM_INPUTS));
        end else if (accept) begin
            last <= winner;
        end
    end

    assign ptr = last;
`endif

    rr_arbiter #(
        .N  (NUM_INPUTS),
        .IW (INDEX_TYPE)
    ) u_rr_arbiter (
        .req    (ins_valid),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .any    (any_grant)
    );

    assign accept    = !full && any_grant;
    assign ins_ready = full ? '0 : grant;

    // Drain and accept are mutually exclusive: a full slot never accepts,
    // which is what keeps outs_ready out of the ins_ready path.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            data_reg <= '0;
            idx_reg  <= '0;
        end else if (full) begin
            if (outs_ready) begin
                full <= 1'b0;
            end
        end else if (any_grant) begin
            full     <= 1'b1;
            data_reg <= ins_arr[winner];
            idx_reg  <= winner;
        end
    end

    assign outs       = data_reg;
    assign outs_valid = full;
    assign index      = idx_reg;

endmodule

// File: tb/tb_merge_arbiter_break_dvr.sv
// Purpose: self-checking bench for merge_arbiter_break_dvr (4-input main instance, 3-input wrap instance).
// Latency: drives inputs 1 time unit after the rising edge, samples on the falling edge.
// Backpressure: outs_ready driven from tables, hand sequences and random stimulus.
module tb_merge_arbiter_break_dvr;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] ins = '0;
    logic [N-1:0]   v   = '0;
    logic [N-1:0]   ins_ready;
    logic [W-1:0]   outs;
    logic           outs_valid;
    logic           ordy = 1'b0;
    logic [1:0]     index;

    logic [3*W-1:0] ins3  = '0;
    logic [2:0]     v3    = '0;
    logic [2:0]     rdy3;
    logic [W-1:0]   outs3;
    logic           ov3;
    logic           ordy3 = 1'b0;
    logic [1:0]     idx3;

    int checks = 0;
    int errors = 0;

    // Reference model state: slot content and most recent winner.
    logic        m_full = 1'b0;
    logic [31:0] m_data = '0;
    int          m_idx  = 0;
    int          m_last = N - 1;

    always #5 clk = ~clk;

    merge_arbiter_break_dvr #(.NUM_INPUTS(N), .DATA_TYPE(W)) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(v), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(ordy), .index(index)
    );

    merge_arbiter_break_dvr #(.NUM_INPUTS(3), .DATA_TYPE(W)) dut3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(v3), .ins_ready(rdy3),
        .outs(outs3), .outs_valid(ov3), .outs_ready(ordy3), .index(idx3)
    );

    typedef struct {
        logic [3:0]  v;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [31:0] o;
        logic [1:0]  ix;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // First valid input searching from one past the last winner, wrapping.
    function automatic int m_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic sample();
        int p;
        logic [3:0] er;
        @(negedge clk);
        p  = m_pick(v, m_last);
        er = (!m_full && p >= 0) ? 4'(1 << p) : 4'b0;
        chk("model ins_ready", 32'(ins_ready), 32'(er));
        chk("model outs_valid", 32'(outs_valid), 32'(m_full));
        chk("model outs", outs, m_data);
        chk("model index", 32'(index), 32'(m_idx));
    endtask

    task automatic advance();
        int p;
        @(posedge clk);
        p = m_pick(v, m_last);
        if (rst) begin
            m_full = 1'b0; m_data = '0; m_idx = 0; m_last = N - 1;
        end else if (m_full) begin
            if (ordy) m_full = 1'b0;
        end else if (p >= 0) begin
            m_full = 1'b1; m_data = ins[p*W +: W]; m_idx = p; m_last = p;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        int tok_idx [$];
        int tok_cyc [$];

        // Reset, then idle.
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sample();
            chk("idle outs_valid", 32'(outs_valid), 32'd0);
            chk("idle ins_ready", 32'(ins_ready), 32'd0);
            advance();
        end

        // Reset while the slot is full discards it.
        ins[0*W +: W] = 32'h0000_00EE;
        v = 4'b0001;
        cyc();
        v = 4'b0000; ordy = 1'b0; rst = 1'b1;
        sample();
        chk("pre-reset outs_valid", 32'(outs_valid), 32'd1);
        advance();
        rst = 1'b0;
        sample();
        chk("post-reset outs_valid", 32'(outs_valid), 32'd0);
        chk("post-reset outs", outs, 32'd0);
        advance();

        // Table-driven sequence from the empty, pointer=3 state.
        ins[0*W +: W] = 32'h11; ins[1*W +: W] = 32'h22;
        ins[2*W +: W] = 32'hA5; ins[3*W +: W] = 32'h44;
        tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 32'h00, 2'd0};
        tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 32'hA5, 2'd2};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 32'hA5, 2'd2};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b0, 32'hA5, 2'd2};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 32'h44, 2'd3};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 32'h44, 2'd3};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 32'h11, 2'd0};
        tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b0, 32'h11, 2'd0};
        tbl[8]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 32'h22, 2'd1};
        tbl[9]  = '{4'b1000, 1'b1, 4'b0000, 1'b1, 32'h22, 2'd1};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h22, 2'd1};
        tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b0, 32'h22, 2'd1};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 32'h44, 2'd3};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h44, 2'd3};
        for (int r = 0; r < 14; r++) begin
            v = tbl[r].v; ordy = tbl[r].ordy;
            sample();
            chk($sformatf("tbl[%0d] ins_ready", r), 32'(ins_ready), 32'(tbl[r].rdy));
            chk($sformatf("tbl[%0d] outs_valid", r), 32'(outs_valid), 32'(tbl[r].ov));
            chk($sformatf("tbl[%0d] outs", r), outs, tbl[r].o);
            chk($sformatf("tbl[%0d] index", r), 32'(index), 32'(tbl[r].ix));
            advance();
        end

        // Withdraw: input 1 would win behind a full slot but drops valid.
        v = 4'b0001; ordy = 1'b0; cyc();
        v = 4'b1010; ordy = 1'b0; cyc();
        v = 4'b1000; ordy = 1'b1; cyc();
        v = 4'b1000; ordy = 1'b1;
        sample();
        chk("withdraw ins_ready", 32'(ins_ready), 32'b1000);
        advance();
        v = 4'b0000; ordy = 1'b0;
        sample();
        chk("withdraw index", 32'(index), 32'd3);
        advance();

        // Backpressure: held for 5 cycles, then released.
        v = 4'b1111; ordy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("bp ins_ready", 32'(ins_ready), 32'd0);
            chk("bp outs", outs, 32'h44);
            chk("bp index", 32'(index), 32'd3);
            advance();
        end
        ordy = 1'b1; cyc();
        sample();
        chk("bp release ins_ready", 32'(ins_ready), 32'b0001);
        advance();

        // Fairness from reset with all inputs valid.
        rst = 1'b1; advance(); rst = 1'b0;
        v = 4'b1111; ordy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (outs_valid === 1'b1) begin
                tok_idx.push_back(int'(index));
                tok_cyc.push_back(c);
            end
            advance();
        end
        chk("fair token count", 32'(tok_idx.size()), 32'd6);
        for (int k = 0; k < tok_idx.size(); k++) begin
            chk($sformatf("fair idx[%0d]", k), 32'(tok_idx[k]), 32'(k % 4));
            if (k > 0) chk($sformatf("fair gap[%0d]", k), 32'(tok_cyc[k] - tok_cyc[k-1]), 32'd2);
        end

        // Three-input instance: wrap from pointer 2 back to input 0.
        v = 4'b0000;
        rst = 1'b1; advance(); rst = 1'b0;
        ins3 = {32'h33, 32'h22, 32'h11};
        v3 = 3'b101; ordy3 = 1'b1;
        sample(); chk("n3 rdy c0", 32'(rdy3), 32'b001); advance();
        sample(); chk("n3 idx c1", 32'(idx3), 32'd0); chk("n3 outs c1", outs3, 32'h11);
                  chk("n3 ov c1", 32'(ov3), 32'd1); advance();
        sample(); chk("n3 rdy c2", 32'(rdy3), 32'b100); advance();
        sample(); chk("n3 idx c3", 32'(idx3), 32'd2); chk("n3 outs c3", outs3, 32'h33); advance();
        sample(); chk("n3 rdy c4", 32'(rdy3), 32'b001); advance();
        v3 = 3'b000; ordy3 = 1'b0;

        // Randomized traffic with occasional resets against the model.
        for (int c = 0; c < 800; c++) begin
            v    = 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) ins[i*W +: W] = $urandom;
            cyc();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/merge_arbiter_break_dvr.md
# merge_arbiter_break_dvr

N-input merge that shares a single one-slot break-DVR output register between competing handshake producers. Each cycle the slot is empty, a round-robin arbiter picks one valid input, captures its data and source index into the slot, and presents them downstream. It sits wherever several dataflow branches converge on one consumer and data, valid and ready paths must all be cut. `ins_ready` depends only on slot state and `ins_valid`, never on `outs_ready`.

## Interface
- NUM_INPUTS, 4, number of requesters (≥2)
- DATA_TYPE, 32, payload width
- INDEX_TYPE, $clog2(NUM_INPUTS), width of winner index
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ins  in  NUM_INPUTS*DATA_TYPE  packed payloads, input i at bits [i*DATA_TYPE +: DATA_TYPE]
- ins_valid  in  NUM_INPUTS  per-input valid
- ins_ready  out  NUM_INPUTS  per-input ready, one-hot or zero
- outs  out  DATA_TYPE  registered payload
- outs_valid  out  1  slot full
- outs_ready  in  1  consumer ready
- index  out  INDEX_TYPE  registered source index of current payload

## Operation
- State: `full` flag, `dataReg`, `idxReg`, round-robin pointer `last` (index of most recent winner).
- Grant (combinational): search ins_valid starting at `(last+1) mod NUM_INPUTS`, wrapping; first valid wins. No valid → no grant.
- `ins_ready[i] = !full & grant[i]`; at most one bit set.
- Accept when `!full` and a grant exists: `dataReg <= ins[winner]`, `idxReg <= winner`, `full <= 1`, `last <= winner`.
- Drain when `full & outs_ready`: `full <= 0`. No accept in that same cycle (ready path cut).
- `last` updates only on accept; rejected or idle cycles leave it unchanged.
- Grant is not sticky: if the winner drops valid before accept, next cycle re-arbitrates from the same pointer.
- Pointer arithmetic wraps modulo NUM_INPUTS, including non-power-of-two values. Indices ≥ NUM_INPUTS never produced.

## Timing
- Reset: outs_valid=0, outs=0, index=0, ins_ready=0 until the first post-reset cycle evaluates, `last` = NUM_INPUTS-1 so input 0 has first priority.
- Reset mid-transfer discards slot contents, no output handshake occurs.
- Latency: accept in cycle t → outs_valid=1 in t+1.
- Throughput: one token per 2 cycles maximum (accept, drain).
- outs/index stable while outs_valid=1 and outs_ready=0.
- Fairness: with all inputs continuously valid, each input wins exactly once per NUM_INPUTS accepts.

## Configuration
- MERGE_ARB_FIXED_PRIORITY_EN defined: pointer removed, search always starts at input 0 (lowest index wins); `last` absent.
- Undefined (default): round-robin as above.

## Structure
- Package `merge_arb_pkg`: index-width function (clog2 with minimum 1), reset constant for pointer.
- Sub-module `rr_arbiter`: combinational grant from request vector and pointer, outputs one-hot grant and binary winner; shared with future multi-requester blocks. Slot register and `full` flag stay in top.

## Test plan
- Reset then idle: all ins_valid=0 → outs_valid=0, ins_ready=0 for 10 cycles.
- Single request: NUM_INPUTS=4, ins_valid=4'b0100, ins[2]=0xA5 → ins_ready=4'b0100 in cycle 0, outs=0xA5, index=2, outs_valid=1 in cycle 1.
- Fairness: all four valid continuously, outs_ready=1 → index sequence 0,1,2,3,0,1 at one token per 2 cycles.
- Backpressure: slot full, outs_ready=0 for 5 cycles → ins_ready=0, outs/index unchanged; release → drain, new accept the following cycle.
- Withdraw: input 1 granted but drops valid, input 3 valid → input 3 accepted, `last` not advanced past 1 beforehand.
- NUM_INPUTS=3 wrap: last=2, inputs 0 and 2 valid → input 0 wins; with MERGE_ARB_FIXED_PRIORITY_EN same stimulus always picks 0.
